// File: rtl/data_mem_ctrl.sv
// MEM-stage data access responder: word-addressed RAM behind a fixed multi-cycle
// access latency, with a stall (mem_busy), a completion pulse (mem_done) and an error pulse (mem_err).
module data_mem_ctrl #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  mem_busy,
  output logic                  mem_done,
  output logic                  mem_err
);

  // state | meaning
  // IDLE  | waiting for mem_read/mem_write; latches the request when one arrives
  // WAIT  | access latency countdown; commits the access when the counter reaches 0
  // DONE  | one-cycle completion (mem_done, mem_err from the latched error flag)
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CNT_W = $clog2(LATENCY + 1);

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    op_wr_q, op_wr_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic                    err_q, err_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    ram_we;
  logic                    req;
  logic                    bad;
  logic [ADDR_WIDTH-1:0]   idx_full;

  logic [DATA_WIDTH-1:0]   ram [DEPTH_WORDS];

  assign rdata = rdata_q;

  always_comb begin
    req      = mem_read | mem_write;
    idx_full = {2'b00, addr[ADDR_WIDTH-1:2]};
    bad      = (mem_read & mem_write) | (addr[1:0] != 2'b00) |
               (idx_full >= ADDR_WIDTH'(DEPTH_WORDS));

    state_d  = state_q;
    cnt_d    = cnt_q;
    op_wr_d  = op_wr_q;
    idx_d    = idx_q;
    wdata_d  = wdata_q;
    err_d    = err_q;
    rdata_d  = rdata_q;
    ram_we   = 1'b0;
    mem_busy = 1'b0;
    mem_done = 1'b0;
    mem_err  = 1'b0;

    case (state_q)
      IDLE: begin
        if (req) begin
          mem_busy = 1'b1;
          op_wr_d  = mem_write;
          idx_d    = addr[IDX_W+1:2];
          wdata_d  = wdata;
          err_d    = bad;
          if (bad) begin
            state_d = DONE;
          end else begin
            cnt_d   = CNT_W'(LATENCY - 1);
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        mem_busy = 1'b1;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d = DONE;
          if (op_wr_q) ram_we  = 1'b1;
          else         rdata_d = ram[idx_q];
        end
      end
      DONE: begin
        mem_done = 1'b1;
        mem_err  = err_q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_wr_q <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_wr_q <= op_wr_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // RAM is not reset; a reset on the commit edge suppresses the write.
  always_ff @(posedge clk) begin
    if (ram_we && !rst) ram[idx_q] <= wdata_q;
  end

endmodule
